// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST sequencer: state encoding,
// vector-entry field layout and MISR polynomial/seed.
package bist_pkg;

    localparam int ENTRY_W  = 10;
    localparam int X_LSB    = 0;
    localparam int X_W      = 5;
    localparam int EXP_LSB  = 5;
    localparam int EXP_W    = 4;
    localparam int LAST_BIT = 9;

    // x^16 + x^12 + x^5 + 1
    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_APPLY   = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_COMPARE = 3'd4,
        ST_FINISH  = 3'd5
    } state_t;

    function automatic logic [15:0] misr_next(input logic [15:0] sig, input logic [3:0] din);
        misr_next = {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ {12'h000, din};
    endfunction

endpackage

// File: rtl/bist_sequencer_if.sv
// TAP-side load/start/status bundle of the BIST sequencer.
interface bist_sequencer_if
    import bist_pkg::*;
#(
    parameter int DEPTH = 256
);
    localparam int AW = $clog2(DEPTH);

    logic               load_clear;
    logic               load_valid;
    logic [ENTRY_W-1:0] load_data;
    logic               start;
    logic               busy;
    logic               done;
    logic               pass;
    logic [AW:0]        fail_count;
    logic [AW-1:0]      first_fail_addr;
    logic               overflow;
    logic [15:0]        signature;

    modport master (
        output load_clear, load_valid, load_data, start,
        input  busy, done, pass, fail_count, first_fail_addr, overflow, signature
    );

    modport slave (
        input  load_clear, load_valid, load_data, start,
        output busy, done, pass, fail_count, first_fail_addr, overflow, signature
    );

endinterface

// File: rtl/bist_misr.sv
// 16-bit multiple-input signature register compressing the 4-bit CUT response.
module bist_misr
    import bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_en,
    input  logic [3:0]  i_data,
    output logic [15:0] o_sig
);

    logic [15:0] r_sig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= '0;
        end else if (i_clear) begin
            r_sig <= MISR_SEED;
        end else if (i_en) begin
            r_sig <= misr_next(r_sig, i_data);
        end
    end

    assign o_sig = r_sig;

endmodule

// File: rtl/bist_sequencer.sv
// BIST sequencer: owns the vector memory, applies stimuli to the CUT and scores responses.
// Optional MISR signature is built only when BIST_SIGNATURE_EN is defined.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | loads accepted, waiting for start
//   FETCH   | synchronous read of entry ra (empty memory exits to FINISH)
//   APPLY   | latch entry, drive cut_x
//   SETTLE  | hold cut_x for SETTLE cycles (down-counter)
//   COMPARE | sample cut_y, score, advance or finish
//   FINISH  | publish done/pass, back to IDLE
module bist_sequencer
    import bist_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int SETTLE = 2
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    bist_sequencer_if.slave        bus,
    output logic [X_W-1:0]         cut_x,
    input  logic [EXP_W-1:0]       cut_y
);

    localparam int          AW          = $clog2(DEPTH);
    localparam logic [AW:0] WP_ONE      = (AW+1)'(1);
    localparam logic [AW:0] WP_FULL     = (AW+1)'(DEPTH);
    localparam logic [AW:0] FC_MAX      = '1;
    localparam logic [AW-1:0] RA_ONE    = AW'(1);
    localparam logic [3:0]  SETTLE_INIT = 4'(SETTLE - 1);

    state_t             r_state;
    state_t             w_next;
    logic [AW:0]        r_wp;
    logic [AW-1:0]      r_ra;
    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [ENTRY_W-1:0] r_rd_data;
    logic [EXP_W-1:0]   r_exp;
    logic               r_last;
    logic [X_W-1:0]     r_cut_x;
    logic [3:0]         r_settle_cnt;
    logic [AW:0]        r_fail_count;
    logic [AW-1:0]      r_first_fail;
    logic               r_done;
    logic               r_pass;
    logic               r_overflow;
    logic               w_ra_is_end;
    logic               w_load_ok;
    logic [15:0]        w_signature;

    assign w_ra_is_end = ({1'b0, r_ra} == (r_wp - WP_ONE));
    assign w_load_ok   = (r_state == ST_IDLE) && !bus.load_clear && bus.load_valid && (r_wp != WP_FULL);

    // An empty run still passes through FETCH so done lands two cycles after start.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (bus.start) w_next = ST_FETCH;
            ST_FETCH:   w_next = (r_wp == '0) ? ST_FINISH : ST_APPLY;
            ST_APPLY:   w_next = ST_SETTLE;
            ST_SETTLE:  if (r_settle_cnt == 4'd0) w_next = ST_COMPARE;
            ST_COMPARE: w_next = (r_last || w_ra_is_end) ? ST_FINISH : ST_FETCH;
            ST_FINISH:  w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_wp         <= '0;
            r_ra         <= '0;
            r_exp        <= '0;
            r_last       <= 1'b0;
            r_cut_x      <= '0;
            r_settle_cnt <= '0;
            r_fail_count <= '0;
            r_first_fail <= '0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (bus.load_clear) begin
                        r_wp       <= '0;
                        r_overflow <= 1'b0;
                        r_done     <= 1'b0;
                    end else if (bus.load_valid) begin
                        if (r_wp == WP_FULL) r_overflow <= 1'b1;
                        else                 r_wp       <= r_wp + WP_ONE;
                    end
                    if (bus.start) begin
                        r_fail_count <= '0;
                        r_first_fail <= '0;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                        r_ra         <= '0;
                    end
                end
                ST_APPLY: begin
                    r_exp        <= r_rd_data[EXP_LSB +: EXP_W];
                    r_last       <= r_rd_data[LAST_BIT];
                    r_cut_x      <= r_rd_data[X_LSB +: X_W];
                    r_settle_cnt <= SETTLE_INIT;
                end
                ST_SETTLE: begin
                    if (r_settle_cnt != 4'd0) r_settle_cnt <= r_settle_cnt - 4'd1;
                end
                ST_COMPARE: begin
                    if (cut_y != r_exp) begin
                        if (r_fail_count != FC_MAX) r_fail_count <= r_fail_count + WP_ONE;
                        if (r_fail_count == '0)     r_first_fail <= r_ra;
                    end
                    if (w_next == ST_FETCH) r_ra <= r_ra + RA_ONE;
                end
                ST_FINISH: begin
                    r_done <= 1'b1;
                    r_pass <= (r_fail_count == '0);
                end
                default: ;
            endcase
        end
    end

    // Vector memory: no reset, contents persist across runs.
    always_ff @(posedge clk) begin
        if (w_load_ok) r_mem[r_wp[AW-1:0]] <= bus.load_data;
        r_rd_data <= r_mem[r_ra];
    end

`ifdef BIST_SIGNATURE_EN
    logic w_misr_clear;
    logic w_misr_en;

    assign w_misr_clear = (r_state == ST_IDLE) && bus.start;
    assign w_misr_en    = (r_state == ST_COMPARE);

    bist_misr u_misr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_misr_clear),
        .i_en    (w_misr_en),
        .i_data  (cut_y),
        .o_sig   (w_signature)
    );
`else
    assign w_signature = 16'h0000;
`endif

    assign cut_x               = r_cut_x;
    assign bus.busy            = (r_state != ST_IDLE);
    assign bus.done            = r_done;
    assign bus.pass            = r_pass;
    assign bus.fail_count      = r_fail_count;
    assign bus.first_fail_addr = r_first_fail;
    assign bus.overflow        = r_overflow;
    assign bus.signature       = w_signature;

endmodule

// File: tb/tb_bist_sequencer.sv
// Scoreboard bench for bist_sequencer: a DEPTH=256 and a DEPTH=4 instance, each with its own CUT model.
module tb_bist_sequencer;

    typedef struct {
        int          done_edge;
        logic        pass;
        int          fc;
        int          ffa;
        logic [15:0] sig;
    } exp_t;

`ifdef BIST_SIGNATURE_EN
    localparam bit SIG_EN = 1'b1;
`else
    localparam bit SIG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n_a, rst_n_b;
    logic [4:0] cut_x_a, cut_x_b;
    logic [3:0] cut_y_a, cut_y_b;
    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    exp_t sb_a[$];
    exp_t sb_b[$];
    logic [4:0] xq_a[$];
    logic [4:0] xq_b[$];
    logic prev_done_a = 1'b0;
    logic prev_done_b = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    bist_sequencer_if #(.DEPTH(256)) bus_a ();
    bist_sequencer_if #(.DEPTH(4))   bus_b ();

    bist_sequencer #(.DEPTH(256), .SETTLE(2)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .bus(bus_a), .cut_x(cut_x_a), .cut_y(cut_y_a));
    bist_sequencer #(.DEPTH(4), .SETTLE(2)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .bus(bus_b), .cut_x(cut_x_b), .cut_y(cut_y_b));

    function automatic logic [3:0] cut_f(input logic [4:0] x);
        return x[3:0] ^ {x[4], 3'b011};
    endfunction

    assign cut_y_a = cut_f(cut_x_a);
    assign cut_y_b = cut_f(cut_x_b);

    function automatic logic [9:0] ent(input logic last, input logic [3:0] y, input logic [4:0] x);
        return {last, y, x};
    endfunction

    function automatic logic [15:0] misr_ref(input logic [15:0] s, input logic [3:0] y);
        logic [15:0] n;
        n = s << 1;
        if (s[15]) n = n ^ 16'h1021;
        return n ^ {12'h000, y};
    endfunction

    function automatic logic [15:0] exp_sig(input bit b, input int n);
        logic [15:0] s;
        logic [4:0]  x;
        s = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            x = b ? xq_b[i] : xq_a[i];
            s = misr_ref(s, cut_f(x));
        end
        return SIG_EN ? s : 16'h0000;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_result(input string tag, input exp_t e, input logic ps, input int fc,
                                input int ffa, input logic [15:0] sig, input logic bsy);
        chk({tag, " done_edge"}, edge_n, e.done_edge);
        chk({tag, " pass"}, int'(ps), int'(e.pass));
        chk({tag, " fail_count"}, fc, e.fc);
        chk({tag, " first_fail_addr"}, ffa, e.ffa);
        chk({tag, " signature"}, int'(sig), int'(e.sig));
        chk({tag, " busy_at_done"}, int'(bsy), 0);
    endtask

    // Monitors: score every rising edge of done against the oldest expectation.
    always @(negedge clk) begin
        if (bus_a.done && !prev_done_a) begin
            if (sb_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL A unexpected_done: got done=1 expected no pending run");
            end else begin
                check_result("A", sb_a.pop_front(), bus_a.pass, int'(bus_a.fail_count),
                             int'(bus_a.first_fail_addr), bus_a.signature, bus_a.busy);
            end
        end
        prev_done_a = bus_a.done;
    end

    always @(negedge clk) begin
        if (bus_b.done && !prev_done_b) begin
            if (sb_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL B unexpected_done: got done=1 expected no pending run");
            end else begin
                check_result("B", sb_b.pop_front(), bus_b.pass, int'(bus_b.fail_count),
                             int'(bus_b.first_fail_addr), bus_b.signature, bus_b.busy);
            end
        end
        prev_done_b = bus_b.done;
    end

    task automatic drive(input bit b, input logic clr, input logic lv, input logic st, input logic [9:0] d);
        @(negedge clk);
        if (b) begin
            bus_b.load_clear = clr; bus_b.load_valid = lv; bus_b.start = st; bus_b.load_data = d;
        end else begin
            bus_a.load_clear = clr; bus_a.load_valid = lv; bus_a.start = st; bus_a.load_data = d;
        end
        @(negedge clk);
        bus_a.load_clear = 1'b0; bus_a.load_valid = 1'b0; bus_a.start = 1'b0;
        bus_b.load_clear = 1'b0; bus_b.load_valid = 1'b0; bus_b.start = 1'b0;
    endtask

    task automatic load(input bit b, input logic [9:0] d);
        drive(b, 1'b0, 1'b1, 1'b0, d);
        if (b) begin
            if (xq_b.size() < 4) xq_b.push_back(d[4:0]);
        end else begin
            if (xq_a.size() < 256) xq_a.push_back(d[4:0]);
        end
    endtask

    task automatic clear(input bit b);
        drive(b, 1'b1, 1'b0, 1'b0, 10'h000);
        if (b) xq_b.delete(); else xq_a.delete();
    endtask

    task automatic run(input bit b, input int lat, input logic ps, input int fc, input int ffa, input int n);
        exp_t e;
        @(negedge clk);
        e.done_edge = edge_n + 1 + lat;
        e.pass = ps; e.fc = fc; e.ffa = ffa; e.sig = exp_sig(b, n);
        if (b) begin sb_b.push_back(e); bus_b.start = 1'b1; end
        else   begin sb_a.push_back(e); bus_a.start = 1'b1; end
        @(negedge clk);
        bus_a.start = 1'b0; bus_b.start = 1'b0;
    endtask

    task automatic drain(input bit b);
        int k = 0;
        while (((b ? sb_b.size() : sb_a.size()) != 0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) begin
            checks++; errors++;
            $display("FAIL drain_timeout dut=%0d: got %0d pending runs expected 0", b, b ? sb_b.size() : sb_a.size());
            if (b) sb_b.delete(); else sb_a.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        bus_a.load_clear = 1'b0; bus_a.load_valid = 1'b0; bus_a.start = 1'b0; bus_a.load_data = '0;
        bus_b.load_clear = 1'b0; bus_b.load_valid = 1'b0; bus_b.start = 1'b0; bus_b.load_data = '0;
        repeat (3) @(negedge clk);
        chk("rst cut_x", int'(cut_x_a), 0);
        chk("rst busy", int'(bus_a.busy), 0);
        chk("rst done", int'(bus_a.done), 0);
        chk("rst pass", int'(bus_a.pass), 0);
        chk("rst fail_count", int'(bus_a.fail_count), 0);
        chk("rst first_fail_addr", int'(bus_a.first_fail_addr), 0);
        chk("rst overflow", int'(bus_a.overflow), 0);
        chk("rst signature", int'(bus_a.signature), 0);
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        repeat (2) @(negedge clk);

        // Five matching entries, run twice
        load(0, ent(1'b0, 4'h1, 5'h02));
        load(0, ent(1'b0, 4'h9, 5'h12));
        load(0, ent(1'b0, 4'h3, 5'h00));
        load(0, ent(1'b0, 4'h7, 5'h04));
        load(0, ent(1'b1, 4'h9, 5'h0A));
        run(0, 26, 1'b1, 0, 0, 5); drain(0);
        run(0, 26, 1'b1, 0, 0, 5); drain(0);

        // Entry 2 expected value corrupted
        clear(0);
        load(0, ent(1'b0, 4'h1, 5'h02));
        load(0, ent(1'b0, 4'h9, 5'h12));
        load(0, ent(1'b0, 4'hE, 5'h00));
        load(0, ent(1'b0, 4'h7, 5'h04));
        load(0, ent(1'b1, 4'h9, 5'h0A));
        run(0, 26, 1'b0, 1, 2, 5); drain(0);

        // 11 entries, last flag on entry 4; mismatches at 1 and 3 (and 6, never reached)
        clear(0);
        load(0, ent(1'b0, 4'h3, 5'h00));
        load(0, ent(1'b0, 4'hD, 5'h01));
        load(0, ent(1'b0, 4'h1, 5'h02));
        load(0, ent(1'b0, 4'h8, 5'h03));
        load(0, ent(1'b1, 4'h7, 5'h04));
        load(0, ent(1'b0, 4'h6, 5'h05));
        load(0, ent(1'b0, 4'h0, 5'h06));
        load(0, ent(1'b0, 4'h4, 5'h07));
        load(0, ent(1'b0, 4'hB, 5'h08));
        load(0, ent(1'b0, 4'hA, 5'h09));
        load(0, ent(1'b0, 4'h9, 5'h0A));
        run(0, 26, 1'b0, 2, 1, 5); drain(0);
        run(0, 26, 1'b0, 2, 1, 5); drain(0);

        // Clear and load in the same cycle: clear wins, so the run is empty
        drive(0, 1'b1, 1'b1, 1'b0, ent(1'b1, 4'h3, 5'h00));
        xq_a.delete();
        chk("A done cleared by load_clear", int'(bus_a.done), 0);
        run(0, 2, 1'b1, 0, 0, 0); drain(0);

        // DEPTH=4: loads and start while busy are ignored
        clear(1);
        load(1, ent(1'b0, 4'h2, 5'h01));
        load(1, ent(1'b0, 4'h7, 5'h05));
        load(1, ent(1'b0, 4'h4, 5'h1F));
        run(1, 16, 1'b0, 1, 1, 3);
        drive(1, 1'b0, 1'b1, 1'b0, ent(1'b0, 4'h0, 5'h1F));
        drive(1, 1'b0, 1'b0, 1'b1, 10'h000);
        drain(1);
        repeat (20) @(negedge clk);
        run(1, 16, 1'b0, 1, 1, 3); drain(1);

        // DEPTH=4 overflow: six loads, only four stored
        clear(1);
        load(1, ent(1'b0, 4'h2, 5'h01));
        load(1, ent(1'b0, 4'h1, 5'h02));
        load(1, ent(1'b0, 4'h0, 5'h03));
        load(1, ent(1'b0, 4'h7, 5'h04));
        chk("B overflow at full", int'(bus_b.overflow), 0);
        load(1, ent(1'b0, 4'h6, 5'h05));
        chk("B overflow after drop", int'(bus_b.overflow), 1);
        load(1, ent(1'b0, 4'h5, 5'h06));
        run(1, 21, 1'b1, 0, 0, 4); drain(1);
        chk("B overflow sticky", int'(bus_b.overflow), 1);

        // Reset pulled mid-SETTLE
        drive(1, 1'b0, 1'b0, 1'b1, 10'h000);
        repeat (2) @(negedge clk);
        chk("B busy before abort", int'(bus_b.busy), 1);
        chk("B cut_x before abort", int'(cut_x_b), 1);
        #2 rst_n_b = 1'b0;
        #1;
        chk("B abort cut_x", int'(cut_x_b), 0);
        chk("B abort busy", int'(bus_b.busy), 0);
        chk("B abort done", int'(bus_b.done), 0);
        chk("B abort pass", int'(bus_b.pass), 0);
        chk("B abort fail_count", int'(bus_b.fail_count), 0);
        chk("B abort overflow", int'(bus_b.overflow), 0);
        chk("B abort signature", int'(bus_b.signature), 0);
        @(negedge clk);
        rst_n_b = 1'b1;
        repeat (5) @(negedge clk);
        chk("B idle after abort", int'(bus_b.busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
